// File: rtl/ui_pkg.sv
// Shared constants for the arrow-instruction UI: direction codes, sequencer
// state encoding and the default instruction-box geometry used by the drawers.
package ui_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_ARM   = 3'd2;
    localparam logic [2:0] ST_DRAW  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [7:0] BOX_X0_DEF = 8'd72;
    localparam logic [6:0] BOX_Y0_DEF = 7'd52;
    localparam int         BOX_W_DEF  = 16;
    localparam int         BOX_H_DEF  = 12;

    function automatic logic [3:0] lane_onehot(input logic [1:0] d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/box_sweeper.sv
// Row-major rectangle walker: column runs 0..BOX_W-1, then the row advances.
// Used to erase the instruction box one pixel per cycle.
module box_sweeper
    import ui_pkg::*;
#(
    parameter int BOX_W = BOX_W_DEF,
    parameter int BOX_H = BOX_H_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       run,
    output logic [4:0] col,
    output logic [4:0] row,
    output logic       last
);

    localparam logic [4:0] COL_LAST = 5'(BOX_W - 1);
    localparam logic [4:0] ROW_LAST = 5'(BOX_H - 1);

    logic [4:0] col_q, col_d;
    logic [4:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (start) begin
            col_d = 5'd0;
            row_d = 5'd0;
        end else if (run) begin
            if (col_q == COL_LAST) begin
                col_d = 5'd0;
                row_d = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            col_q <= 5'd0;
            row_q <= 5'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/ui_mux.sv
// Sequencer and pixel mux between the four arrow drawers and the VGA adapter.
//   state | meaning
//   IDLE  | waiting for go; drawers held in reset
//   CLEAR | erase the instruction box, one black pixel per cycle
//   ARM   | release drawer reset and enable the selected lane
//   DRAW  | forward the selected lane's pixels for DRAW_CYCLES clocks
//   DONE  | one-cycle completion pulse, drawers back in reset
module ui_mux
    import ui_pkg::*;
#(
    parameter logic [7:0]  BOX_X0      = BOX_X0_DEF,
    parameter logic [6:0]  BOX_Y0      = BOX_Y0_DEF,
    parameter int          BOX_W       = BOX_W_DEF,
    parameter int          BOX_H       = BOX_H_DEF,
    parameter logic [23:0] DRAW_CYCLES = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [1:0]  dir,
    input  logic [2:0]  colour_in,
    input  logic [31:0] ui_x,
    input  logic [27:0] ui_y,
    input  logic [3:0]  ui_we,
    output logic [3:0]  ui_enable,
    output logic        ui_reset_n,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    logic [2:0]  state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [2:0]  colour_q, colour_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  pix_colour_q, pix_colour_d;
    logic        plot_q, plot_d;

    logic [4:0]  sweep_col, sweep_row;
    logic        sweep_last;
    logic [7:0]  lane_x;
    logic [6:0]  lane_y;
    logic        lane_we;

    box_sweeper #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_sweeper (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (state_q == ST_IDLE),
        .run     (state_q == ST_CLEAR),
        .col     (sweep_col),
        .row     (sweep_row),
        .last    (sweep_last)
    );

    always_comb begin
        lane_x  = ui_x[7:0];
        lane_y  = ui_y[6:0];
        lane_we = ui_we[0];
        case (dir_q)
            DIR_UP: begin
                lane_x  = ui_x[7:0];
                lane_y  = ui_y[6:0];
                lane_we = ui_we[0];
            end
            DIR_DOWN: begin
                lane_x  = ui_x[15:8];
                lane_y  = ui_y[13:7];
                lane_we = ui_we[1];
            end
            DIR_LEFT: begin
                lane_x  = ui_x[23:16];
                lane_y  = ui_y[20:14];
                lane_we = ui_we[2];
            end
            DIR_RIGHT: begin
                lane_x  = ui_x[31:24];
                lane_y  = ui_y[27:21];
                lane_we = ui_we[3];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        colour_d     = colour_q;
        cnt_d        = cnt_q;
        x_d          = 8'd0;
        y_d          = 7'd0;
        pix_colour_d = 3'd0;
        plot_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d  = ST_CLEAR;
                    dir_d    = dir;
                    colour_d = colour_in;
                end
            end
            ST_CLEAR: begin
                x_d    = BOX_X0 + {3'b000, sweep_col};
                y_d    = BOX_Y0 + {2'b00, sweep_row};
                plot_d = 1'b1;
                if (sweep_last) state_d = ST_ARM;
            end
            ST_ARM: begin
                cnt_d   = DRAW_CYCLES - 24'd1;
                state_d = ST_DRAW;
            end
            ST_DRAW: begin
                x_d          = lane_x;
                y_d          = lane_y;
                plot_d       = lane_we;
                pix_colour_d = colour_q;
                if (cnt_q == 24'd0) state_d = ST_DONE;
                else                cnt_d   = cnt_q - 24'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= 2'd0;
            colour_q     <= 3'd0;
            cnt_q        <= 24'd0;
            x_q          <= 8'd0;
            y_q          <= 7'd0;
            pix_colour_q <= 3'd0;
            plot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            colour_q     <= colour_d;
            cnt_q        <= cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pix_colour_q <= pix_colour_d;
            plot_q       <= plot_d;
        end
    end

    // Drawers only run while armed or drawing; they see reset everywhere else.
    assign ui_enable  = (state_q == ST_ARM) ? lane_onehot(dir_q) : 4'b0000;
    assign ui_reset_n = (state_q == ST_ARM) || (state_q == ST_DRAW);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = pix_colour_q;
    assign plot       = plot_q;

endmodule

// File: tb/tb_ui_mux.sv
// Directed bench for ui_mux with a short DRAW window; all activity is on the
// falling edge so registered outputs are stable when sampled.
module tb_ui_mux;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        go;
    logic [1:0]  dir;
    logic [2:0]  colour_in;
    logic [31:0] ui_x;
    logic [27:0] ui_y;
    logic [3:0]  ui_we;
    logic [3:0]  ui_enable;
    logic        ui_reset_n;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] lx [4] = '{8'd11, 8'd22, 8'd33, 8'd90};
    logic [6:0] ly [4] = '{7'd15, 7'd25, 7'd35, 7'd60};

    always #5 clk = ~clk;

    ui_mux #(
        .DRAW_CYCLES (24'd4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .dir        (dir),
        .colour_in  (colour_in),
        .ui_x       (ui_x),
        .ui_y       (ui_y),
        .ui_we      (ui_we),
        .ui_enable  (ui_enable),
        .ui_reset_n (ui_reset_n),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Runs one instruction from an IDLE falling edge; c counts cycles after go is accepted.
    task automatic run_instr(input logic [1:0] d, input logic [2:0] cin,
                             input bit hold_go, input int last_c);
        logic [18:0] exp_px;
        int i;
        dir       = d;
        colour_in = cin;
        go        = 1'b1;
        ui_we     = ~lane_onehot_tb(d);
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            if (!hold_go) begin
                go        = (c == 50) || (c == 195);
                dir       = ~d;
                colour_in = ~cin;
            end
            check("busy", {31'd0, busy}, {31'd0, (c <= 198)});
            check("done", {31'd0, done}, {31'd0, (c == 198)});
            check("ui_reset_n", {31'd0, ui_reset_n}, {31'd0, (c >= 193 && c <= 197)});
            check("ui_enable", {28'd0, ui_enable}, {28'd0, (c == 193) ? lane_onehot_tb(d) : 4'b0000});
            if (c >= 2 && c <= 193) begin
                i = c - 2;
                exp_px = {1'b1, 3'b000, 8'(72 + i % 16), 7'(52 + i / 16)};
                check("clr_px", {13'd0, plot, colour, x, y}, {13'd0, exp_px});
            end
            if (c == 1 || c == 194 || c == 195 || c == 199)
                check("plot_idle", {31'd0, plot}, 32'd0);
            if (c == 195) ui_we = 4'b1111;
            if (c == 196)
                check("lane_px", {13'd0, plot, colour, x, y},
                      {13'd0, 1'b1, cin, lx[d], ly[d]});
        end
        ui_we = 4'b0000;
    endtask

    function automatic logic [3:0] lane_onehot_tb(input logic [1:0] d);
        case (d)
            2'd0:    return 4'b0001;
            2'd1:    return 4'b0010;
            2'd2:    return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    initial begin
        reset_n   = 1'b0;
        go        = 1'b0;
        dir       = 2'd0;
        colour_in = 3'd0;
        ui_x      = {lx[3], lx[2], lx[1], lx[0]};
        ui_y      = {ly[3], ly[2], ly[1], ly[0]};
        ui_we     = 4'b0000;

        repeat (3) @(negedge clk);
        check("rst_outs", {12'd0, ui_enable, ui_reset_n, x, y, colour, plot, busy, done}, 32'd0);

        @(negedge clk);
        reset_n = 1'b1;
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Up lane, colour 100, go pulses inside CLEAR and DRAW must be ignored.
        run_instr(2'd0, 3'b100, 1'b0, 205);

        // Right lane with go held high: the next instruction is accepted right after DONE.
        run_instr(2'd3, 3'b101, 1'b1, 198);
        @(negedge clk);
        check("b2b_idle", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        go = 1'b0;
        @(negedge clk);
        check("b2b_first", {13'd0, plot, colour, x, y}, {13'd0, 1'b1, 3'b000, 8'd72, 7'd52});

        repeat (50) @(negedge clk);
        check("px50", {13'd0, plot, colour, x, y}, {13'd0, 1'b1, 3'b000, 8'd74, 7'd55});
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid", {12'd0, ui_enable, ui_reset_n, x, y, colour, plot, busy, done}, 32'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post_rst", {29'd0, plot, busy, done}, 32'd0);
        end

        // Fresh instruction after the abandoned one restarts the sweep at the box origin.
        run_instr(2'd1, 3'b010, 1'b0, 205);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ui_mux.md
# ui_mux

Sequencer and pixel multiplexer between the four arrow-instruction drawers (up/down/left/right) and the VGA adapter. On each new instruction it erases the instruction box, arms exactly one drawer, and forwards that drawer's pixel stream with the instruction colour. It then signals completion to the game controller. It is the downstream consumer of every `ui_<dir>` drawer's `x`/`y`/`writeEn`, and the source of each drawer's `enable_control` and reset.

## Interface
Parameters:
- `BOX_X0`, 8'd72: left column of the instruction box.
- `BOX_Y0`, 7'd52: top row of the instruction box.
- `BOX_W`, 16: box width in pixels (1..32).
- `BOX_H`, 12: box height in pixels (1..32).
- `DRAW_CYCLES`, 24'd10_000_000: length of the DRAW window in clocks (≥2).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset_n`  in  1  reset, synchronous, active-low.
- `go`  in  1  start request; sampled only in IDLE.
- `dir`  in  2  instruction: 0 up, 1 down, 2 left, 3 right; latched on accepted `go`.
- `colour_in`  in  3  instruction colour; latched on accepted `go`.
- `ui_x`  in  32  four 8-bit drawer x buses; lane k = bits [8k+7:8k].
- `ui_y`  in  28  four 7-bit drawer y buses; lane k = bits [7k+6:7k].
- `ui_we`  in  4  drawer write enables, one per lane.
- `ui_enable`  out  4  one-hot `enable_control` to the drawers.
- `ui_reset_n`  out  1  shared active-low reset to the drawers.
- `x`  out  8  pixel x to the VGA adapter.
- `y`  out  7  pixel y to the VGA adapter.
- `colour`  out  3  pixel colour.
- `plot`  out  1  pixel write strobe.
- `busy`  out  1  high from the cycle after accepted `go` until IDLE.
- `done`  out  1  one-cycle pulse at end of an instruction.

## Operation
- **States:** IDLE, CLEAR, ARM, DRAW, DONE.
- **IDLE:**
  - `go`=1 latches `dir` and `colour_in` and goes to CLEAR.
  - Clear counters load (0,0).
- **CLEAR:**
  - Sweeps the box row-major: column counter 0..BOX_W-1, then the row counter increments.
  - Each cycle emits (BOX_X0+col, BOY_Y0+row) with colour 3'b000 and plot=1.
  - After pixel (BOX_W-1, BOX_H-1) it goes to ARM.
  - Duration is exactly BOX_W·BOX_H cycles.
- **ARM:**
  - One cycle.
  - `ui_reset_n`=1 and `ui_enable[dir_q]`=1; all other lanes 0.
  - Then goes to DRAW.
- **DRAW:**
  - Forwards lane `dir_q`: x=`ui_x` lane, y=`ui_y` lane, plot=`ui_we[dir_q]`, colour=`colour_q`.
  - Other lanes are ignored, even if their `ui_we`=1.
  - A down-counter loaded with DRAW_CYCLES-1 expires at 0 and the state goes to DONE.
- **DONE:**
  - One cycle; `done`=1.
  - Then goes to IDLE.
- **`ui_reset_n`:** 0 in IDLE, CLEAR and DONE; 1 in ARM and DRAW. Drawers therefore return to their disabled state between instructions.
- **`go` outside IDLE:** ignored, not queued.
- **`go` held high:** a new instruction starts on the cycle after DONE, which is legal back-to-back operation.
- **Widths:** coordinate sums are 8-/7-bit and wrap modulo 256/128. Parameter ranges guarantee no wrap at defaults.

## Timing
- **Registered outputs:** `x`, `y`, `colour` and `plot` are registered, so each is one cycle after the state or input that produced it. The first CLEAR pixel appears two cycles after accepted `go`.
- **Combinational-from-state outputs:** `ui_enable`, `ui_reset_n`, `busy` and `done` are decoded from the state register, with no extra latency.
- **Drawer latency:** a drawer's first `ui_we` arrives at least 2 cycles after ARM (its ENABLE_STATE→ENABLE_WAIT→DRAW), which lies within DRAW.
- **Reset values:** while `reset_n`=0 at a clock edge, the state goes to IDLE and all outputs are 0 (`ui_reset_n`=0, `ui_enable`=0, `plot`=0, `x`=0, `y`=0, `colour`=0, `busy`=0, `done`=0). Latches and counters clear.
- **Reset mid-operation:** abandons the instruction with no `done`. The next edge with `reset_n`=1 is in IDLE.
- **Instruction length:** total cycles from accepted `go` to `done` = 1 + BOX_W·BOX_H + 1 + DRAW_CYCLES.

## Structure
- **Package `ui_pkg`:**
  - Direction codes DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3.
  - State encoding (3-bit localparams).
  - Default box constants, shared with the drawers.
- **Sub-module `box_sweeper`:**
  - Inputs: clk, reset_n, start, run.
  - Outputs: col, row, last.
  - Row-major rectangle counter parameterised by BOX_W/BOX_H; used for CLEAR.
- **Top level:** FSM, latches, DRAW counter, lane select mux and output registers stay in `ui_mux`.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles → all outputs 0, `ui_reset_n`=0, state IDLE.
- **Clear sweep:** `go`=1 with `dir`=0 and `colour_in`=3'b100 → 192 plot pulses with colour 0, first (72,52), last (87,63), row-major. Then `ui_enable`=4'b0001 for exactly 1 cycle.
- **Lane select:** `dir`=3, with lanes 0–2 driving `ui_we`=1 and lane 3 driving (90,60) with `we`=1 → only (90,60) is plotted, colour=`colour_q`.
- **Done and busy timing (DRAW_CYCLES=4):** → `done` pulse exactly 198 cycles after accepted `go`. `busy` is high from the next cycle through DONE.
- **Go while busy:** `go` pulsed mid-CLEAR and mid-DRAW → ignored; exactly one `done`. With `go` held high, the second CLEAR starts the cycle after DONE.
- **Reset mid-CLEAR:** `reset_n`=0 at pixel 50 → next cycle `plot`=0 and state IDLE; no `done`. A following `go` restarts the sweep at (72,52).
